// File: rtl/sprite_move_pkg.sv
// Shared types and helpers for the sprite step controller.
// Auto-repeat is selected by SPRITE_MOVE_AUTOREPEAT_EN in the files that import this package.
package sprite_move_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } press_state_t;

    // Without auto-repeat the second state simply means "button is down".
    localparam press_state_t HELD = DELAY;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sprite_move_ctrl_btn_debounce.sv
// One button channel front end: 2-FF synchroniser, polarity normalisation to
// pressed=1, and a stable-time debounce counter producing a clean pressed level.
module btn_debounce
    import sprite_move_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int             CW     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          pressed;
    logic [CW-1:0] cnt;

    assign pressed = sync_2 ^ BTN_ACTIVE_LOW;

    // The synchroniser resets to the released raw level so a held button is re-debounced.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= BTN_ACTIVE_LOW;
            sync_2 <= BTN_ACTIVE_LOW;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (pressed == level) begin
                cnt <= '0;
            end else if (cnt == CNT_TC) begin
                level <= pressed;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_move_ctrl.sv
// Turns the raw X/Y push buttons into one-cycle step strobes for sprite_position.
// Define SPRITE_MOVE_AUTOREPEAT_EN to get delayed auto-repeat while a button is held.
module sprite_move_ctrl
    import sprite_move_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_x,
    input  logic btn_y,
    output logic x_increment,
    output logic y_increment,
    output logic x_held,
    output logic y_held
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("sprite_move_ctrl: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic [1:0] btn_raw;
    logic [1:0] level;
    logic [1:0] strobe;

    assign btn_raw = {btn_y, btn_x};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        press_state_t state;
        logic         strobe_r;

        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[ch]),
            .level (level[ch])
        );

`ifdef SPRITE_MOVE_AUTOREPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
        localparam int RW   = cnt_width(RMAX);
        localparam logic [RW-1:0] DELAY_TC = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] RATE_TC  = RW'(REPEAT_RATE - 1);

        logic [RW-1:0] rcnt;

        // Release wins over a terminal count landing on the same cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= IDLE;
                rcnt     <= '0;
                strobe_r <= 1'b0;
            end else begin
                strobe_r <= 1'b0;
                if (!level[ch]) begin
                    state <= IDLE;
                    rcnt  <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            state    <= DELAY;
                            strobe_r <= 1'b1;
                            rcnt     <= '0;
                        end
                        DELAY: begin
                            if (rcnt == DELAY_TC) begin
                                state    <= REPEAT;
                                strobe_r <= 1'b1;
                                rcnt     <= '0;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (rcnt == RATE_TC) begin
                                strobe_r <= 1'b1;
                                rcnt     <= '0;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            rcnt  <= '0;
                        end
                    endcase
                end
            end
        end
`else
        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= IDLE;
                strobe_r <= 1'b0;
            end else begin
                strobe_r <= 1'b0;
                if (!level[ch]) begin
                    state <= IDLE;
                end else begin
                    case (state)
                        IDLE: begin
                            state    <= HELD;
                            strobe_r <= 1'b1;
                        end
                        HELD: state <= HELD;
                        default: state <= HELD;
                    endcase
                end
            end
        end
`endif

        assign strobe[ch] = strobe_r;
    end

    assign x_increment = strobe[0];
    assign y_increment = strobe[1];
    assign x_held      = level[0];
    assign y_held      = level[1];

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Self-checking bench for sprite_move_ctrl: directed scenarios plus random button
// activity, compared every cycle against a history-window / hold-age reference model.
module tb_sprite_move_ctrl;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
`ifdef SPRITE_MOVE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic btn_x;
    logic btn_y;
    logic x_increment;
    logic y_increment;
    logic x_held;
    logic y_held;

    always #5 clk = ~clk;

    sprite_move_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_x       (btn_x),
        .btn_y       (btn_y),
        .x_increment (x_increment),
        .y_increment (y_increment),
        .x_held      (x_held),
        .y_held      (y_held)
    );

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Reference model state: pressed samples since reset, debounced level, hold age.
    bit hist [2][$];
    bit lvl  [2];
    int age  [2];
    bit exp_inc [2];

    int xq[$];
    int yq[$];
    int base;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, edge_no, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit sample(input int ch, input int idx);
        if (idx < 0) return 1'b0;
        return hist[ch][idx];
    endfunction

    function automatic bit strobe_due(input int a);
        if (a == 1) return 1'b1;
        if (AR && (a - 1) >= RD && ((a - 1 - RD) % RR) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input bit r, input bit bx, input bit by);
        if (r) begin
            for (int ch = 0; ch < 2; ch++) begin
                hist[ch].delete();
                lvl[ch]     = 1'b0;
                age[ch]     = 0;
                exp_inc[ch] = 1'b0;
            end
            return;
        end
        hist[0].push_back(!bx);
        hist[1].push_back(!by);
        for (int ch = 0; ch < 2; ch++) begin
            bit prev;
            bit all_differ;
            int n;
            prev = lvl[ch];
            n = hist[ch].size();
            if (prev) begin
                age[ch]++;
                exp_inc[ch] = strobe_due(age[ch]);
            end else begin
                age[ch]     = 0;
                exp_inc[ch] = 1'b0;
            end
            // The level flips once the synchronised input has disagreed for DB straight cycles.
            all_differ = 1'b1;
            for (int k = 0; k < DB; k++)
                if (sample(ch, n - 3 - k) == prev) all_differ = 1'b0;
            if (all_differ) lvl[ch] = !prev;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_no++;
        model_edge(rst, btn_x, btn_y);
        #1;
        check("x_increment", x_increment, exp_inc[0]);
        check("y_increment", y_increment, exp_inc[1]);
        check("x_held", x_held, lvl[0]);
        check("y_held", y_held, lvl[1]);
        if (x_increment === 1'b1) xq.push_back(edge_no - base);
        if (y_increment === 1'b1) yq.push_back(edge_no - base);
    endtask

    task automatic start_phase();
        xq.delete();
        yq.delete();
        base = edge_no;
    endtask

    initial begin
        rst   = 1'b1;
        btn_x = 1'b1;
        btn_y = 1'b1;
        base  = 0;

        // Reset with buttons released
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();

        // Single press, held 8 cycles
        start_phase();
        btn_x = 1'b0;
        repeat (8) tick();
        btn_x = 1'b1;
        repeat (12) tick();
        check_int("press_count", xq.size(), 1);
        if (xq.size() > 0) check_int("press_edge", xq[0], DB + 3);

        // Short glitch on Y
        start_phase();
        btn_y = 1'b0;
        repeat (DB - 1) tick();
        btn_y = 1'b1;
        repeat (10) tick();
        check_int("glitch_count", yq.size(), 0);

        // Long hold on X
        start_phase();
        btn_x = 1'b0;
        repeat (40) tick();
        btn_x = 1'b1;
        repeat (15) tick();
        check_int("hold_count", xq.size(), AR ? 11 : 1);
        if (AR && xq.size() > 2) begin
            check_int("first_repeat", xq[1], DB + 3 + RD);
            check_int("second_repeat", xq[2], DB + 3 + RD + RR);
        end

        // Simultaneous press
        start_phase();
        btn_x = 1'b0;
        btn_y = 1'b0;
        repeat (10) tick();
        btn_x = 1'b1;
        btn_y = 1'b1;
        repeat (10) tick();
        check_int("simul_x_count", xq.size(), 1);
        check_int("simul_y_count", yq.size(), 1);
        if (xq.size() > 0 && yq.size() > 0) check_int("simul_same_edge", xq[0], yq[0]);

        // Reset mid-hold at edge 12
        start_phase();
        btn_x = 1'b0;
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (15) tick();
        check_int("rst_hold_count", xq.size(), 2);
        if (xq.size() > 1) begin
            check_int("rst_first_pulse", xq[0], DB + 3);
            check_int("rst_fresh_pulse", xq[1], 12 + DB + 3);
        end
        btn_x = 1'b1;
        repeat (10) tick();

        // Random button activity with occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) btn_x = ~btn_x;
            if ($urandom_range(0, 11) == 0) btn_y = ~btn_y;
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
